imem_loader: RTL and testbench

//   Boot loader, the write side of the instruction ROM. Takes a byte stream (UART/debug RX)
//   and packs it into 32-bit little-endian words. Writes the words into the instruction memory

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader_byte_word_packer.sv | 50 +++++
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding and frame geometry.
package imem_loader_pkg;

    typedef logic [2:0]  state_t;
    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LEN0 = 3'd1;
    localparam state_t ST_LEN1 = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_CSUM = 3'd4;
    localparam state_t ST_DONE = 3'd5;
    localparam state_t ST_ERR  = 3'd6;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in and instruction-memory write port out of the boot loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    byte_t rx_data;
    logic  rx_valid;
    logic  rx_ready;
    logic  we;
    word_t waddr;
    word_t wdata;

    // master: serial source plus memory sink; slave: the loader itself
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, we, waddr, wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, we, waddr, wdata
    );

endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Packs accepted bytes LSB-first into 32-bit words and emits a registered one-cycle write strobe.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  byte_valid,
    input  byte_t byte_data,
    output logic  word_done,
    output logic  we,
    output word_t wdata
);

    localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned ASM_W  = 8 * (BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane_q;
    logic [ASM_W-1:0]  asm_q;
    logic              we_q;
    word_t             wdata_q;

    assign word_done = byte_valid && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    assign we        = we_q;
    assign wdata     = wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            we_q <= word_done;
            if (clear) begin
                lane_q <= '0;
            end else if (byte_valid) begin
                lane_q <= word_done ? '0 : lane_q + LANE_W'(1);
            end
            // Shift right so the first byte of a word ends up in the lowest lane.
            if (byte_valid) begin
                asm_q <= {byte_data, asm_q[ASM_W-1:8]};
            end
            if (word_done) begin
                wdata_q <= {byte_data, asm_q};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses LEN/DATA/CSUM frames, writes words to instruction memory, gates core reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_rst_n
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH) + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned LEN_W = 8 * LEN_BYTES;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_rx;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    byte_t            xor_q, xor_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    word_t            waddr_q, waddr_d;
    logic             active;
    logic             xfer;
    logic             data_xfer;
    logic             word_done;
    logic             clear;

    assign active = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                    (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign xfer      = bus.rx_valid && active;
    assign data_xfer = xfer && (state_q == ST_DATA);
    assign clear     = start && !active;
    assign len_rx    = {bus.rx_data, len_q[7:0]};

    assign bus.rx_ready = active;
    assign bus.waddr    = waddr_q;
    assign busy         = active;
    assign done         = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERR);
    assign cpu_rst_n    = (state_q == ST_DONE);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .byte_valid (data_xfer),
        .byte_data  (bus.rx_data),
        .word_done  (word_done),
        .we         (bus.we),
        .wdata      (bus.wdata)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        xor_d      = xor_q;
        tmo_d      = tmo_q;
        waddr_d    = waddr_q;
        case (state_q)
            ST_LEN0: begin
                if (xfer) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (xfer) begin
                    len_d = len_rx;
                    if (len_rx == '0 || 32'(len_rx) > MEM_DEPTH) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    xor_d = xor_q ^ bus.rx_data;
                    if (word_done) begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                        waddr_d    = 32'(word_idx_q) << 2;
                        if (LEN_W'(word_idx_q) + LEN_W'(1) == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    state_d = (bus.rx_data == xor_q) ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                if (start) begin
                    state_d    = ST_LEN0;
                    word_idx_d = '0;
                    xor_d      = '0;
                    tmo_d      = '0;
                end
            end
        endcase
        // Idle-byte watchdog overrides whatever the frame parser decided this cycle.
        if (active) begin
            if (xfer) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_d == TMO_W'(TIMEOUT_CYC)) begin
                    state_d = ST_ERR;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            xor_q      <= '0;
            tmo_q      <= '0;
            waddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            xor_q      <= xor_d;
            tmo_q      <= tmo_d;
            waddr_q    <= waddr_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames against a frame-level model of the boot loader.
module tb_imem_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned TMO   = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done, error, cpu_rst_n;

    imem_loader_if bus ();

    imem_loader #(
        .MEM_DEPTH   (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  frame[$];
    logic [63:0] exp_w[$];
    logic [63:0] wq[$];
    bit          exp_ok;
    int          exp_used;

    always @(negedge clk) begin
        if (bus.we === 1'b1) wq.push_back({bus.waddr, bus.wdata});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected writes and outcome derived straight from the frame bytes.
    task automatic model();
        int         n;
        logic [7:0] x;
        logic [31:0] w;
        exp_w.delete();
        n = int'({frame[1], frame[0]});
        if (n == 0 || n > int'(DEPTH)) begin
            exp_ok   = 1'b0;
            exp_used = 2;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = {frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]};
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            exp_w.push_back({32'(4 * i), w});
        end
        exp_used = 3 + 4 * n;
        exp_ok   = (frame[2+4*n] == x);
    endtask

    task automatic build_random(input int n, input bit good);
        logic [7:0] x, b;
        frame.delete();
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            frame.push_back(b);
            x = x ^ b;
        end
        frame.push_back(good ? x : (x ^ 8'($urandom_range(255, 1))));
    endtask

    task automatic load_frame1();
        frame = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00, 8'h90};
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_status", 64'({busy, done, error, cpu_rst_n, bus.rx_ready}), 64'(5'b10001));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
        int waited;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            start        = 1'b0;
        end
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        start        = st;
        waited       = 0;
        while (bus.rx_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("rx_ready", 64'(bus.rx_ready), 64'd1);
        @(posedge clk);
    endtask

    task automatic run_frame(input int gap_max, input int start_at);
        model();
        wq.delete();
        pulse_start();
        for (int i = 0; i < exp_used; i++) begin
            send_byte(frame[i], (gap_max > 0) ? int'($urandom_range(gap_max)) : 0, i == start_at);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        start        = 1'b0;
        repeat (2) @(negedge clk);
        chk("nwrites", 64'(wq.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wq.size(); i++) begin
            chk("write", wq[i], exp_w[i]);
        end
        chk("end_status", 64'({busy, done, error, cpu_rst_n}),
            exp_ok ? 64'(4'b0101) : 64'(4'b0010));
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_status", 64'({bus.rx_ready, bus.we, busy, done, error, cpu_rst_n}), 64'd0);
        chk("reset_waddr", 64'(bus.waddr), 64'd0);
        chk("reset_wdata", 64'(bus.wdata), 64'd0);
        rst_n = 1'b1;

        // Good frame, back-to-back bytes
        load_frame1();
        run_frame(0, -1);

        // Bad checksum still writes both words
        load_frame1();
        frame[10] = 8'h91;
        run_frame(0, -1);

        // Illegal lengths
        frame = {8'h01, 8'h01};
        run_frame(0, -1);
        frame = {8'h00, 8'h00};
        run_frame(0, -1);

        // Random gaps, then an idle stall after byte 5
        load_frame1();
        run_frame(3, -1);
        load_frame1();
        wq.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(frame[i], 0, 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        for (int k = 1; k <= int'(TMO); k++) begin
            @(posedge clk);
            #1;
            if (k == int'(TMO) - 1) chk("tmo_early", 64'({busy, error}), 64'(2'b10));
            if (k == int'(TMO)) chk("tmo_hit", 64'({busy, error, cpu_rst_n}), 64'(3'b010));
        end
        chk("tmo_nwrites", 64'(wq.size()), 64'd0);

        // Reset mid-word after two words were written
        build_random(3, 1'b1);
        pulse_start();
        for (int i = 0; i < 12; i++) send_byte(frame[i], 0, 1'b0);
        @(negedge clk);
        chk("pre_rst_waddr", 64'(bus.waddr), 64'd4);
        bus.rx_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_status", 64'({bus.rx_ready, bus.we, busy, done, error, cpu_rst_n}), 64'd0);
        chk("rst_waddr", 64'(bus.waddr), 64'd0);
        chk("rst_wdata", 64'(bus.wdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_frame1();
        run_frame(0, -1);

        // start during DATA is ignored; start from DONE reloads
        load_frame1();
        run_frame(0, 6);
        load_frame1();
        run_frame(1, -1);

        // Randomized frames, mixed checksums and gaps
        for (int r = 0; r < 6; r++) begin
            build_random(int'($urandom_range(6, 1)), ($urandom_range(3) != 0));
            run_frame(int'($urandom_range(2)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
